// File: rtl/seg7_scan_rx.sv
// seg7_scan_rx: receiver for a multiplexed, active-low 4-digit seven-segment bus.
// A digit is accepted after STABLE_CNT identical samples. Its pattern is decoded
// back to a hex nibble. Complete frames are offered on a valid/ready handshake.
//
// Parameters:
//   STABLE_CNT   identical consecutive samples needed to accept a digit (2..15)
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   seg_i[6:0]   segment lines, active-low, {g,f,e,d,c,b,a}
//   an_i[3:0]    digit anodes, active-low, an_i[3] = most significant digit
//   dp_i         decimal point, active-low (SEG7_SCAN_RX_DP_EN only)
//   ready_i      consumer takes the held frame when high with valid_o
//   value_o      held frame, digit n in nibble n
//   valid_o      a frame is held until it is accepted
//   err_o        held frame contains an unrecognised pattern
//   digit_err_o  per-digit unrecognised-pattern flags of the held frame
//   dp_o[3:0]    per-digit decimal points, active-high (SEG7_SCAN_RX_DP_EN only)
//   overrun_o    sticky: a completed frame was dropped; cleared only by rst
// Build option: define SEG7_SCAN_RX_DP_EN to add decimal-point capture.

module seg7_scan_rx #(
    parameter int STABLE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_i,
    input  logic [3:0]  an_i,
`ifdef SEG7_SCAN_RX_DP_EN
    input  logic        dp_i,
`endif
    input  logic        ready_i,
    output logic [15:0] value_o,
    output logic        valid_o,
    output logic        err_o,
    output logic [3:0]  digit_err_o,
`ifdef SEG7_SCAN_RX_DP_EN
    output logic [3:0]  dp_o,
`endif
    output logic        overrun_o
);

    localparam logic [3:0] STABLE    = 4'(STABLE_CNT);
    localparam logic [3:0] STABLE_M1 = 4'(STABLE_CNT - 1);

    // The whole bus is compared for stability, so a segment glitch on the
    // same digit restarts the count just like a digit change does.
`ifdef SEG7_SCAN_RX_DP_EN
    localparam int SW = 12;
    logic [SW-1:0] sample;
    assign sample = {dp_i, an_i, seg_i};
`else
    localparam int SW = 11;
    logic [SW-1:0] sample;
    assign sample = {an_i, seg_i};
`endif
    localparam logic [SW-1:0] BLANK = '1;

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t        state;
    logic [SW-1:0] prev;
    logic [3:0]    cnt;
    logic [3:0]    cnt_nxt;
    logic [3:0]    mask;
    logic [15:0]   slot_val;
    logic [3:0]    slot_err;
`ifdef SEG7_SCAN_RX_DP_EN
    logic [3:0]    slot_dp;
`endif

    logic          legal;
    logic [1:0]    sel;
    logic [3:0]    hot;
    logic          same;
    logic          capture;
    logic          frame_done;
    logic [3:0]    nib;
    logic          bad;

    // Exactly one anode low selects a digit; blank and ghost states are
    // treated as illegal samples.
    always_comb begin
        legal = 1'b1;
        sel   = 2'd0;
        case (an_i)
            4'b1110: sel = 2'd0;
            4'b1101: sel = 2'd1;
            4'b1011: sel = 2'd2;
            4'b0111: sel = 2'd3;
            default: legal = 1'b0;
        endcase
    end

    assign hot = legal ? ~an_i : 4'b0000;

    // Segment pattern back to nibble; 9 is accepted with or without its
    // bottom segment lit.
    always_comb begin
        nib = 4'h0;
        bad = 1'b0;
        case (seg_i)
            7'b1000000: nib = 4'h0;
            7'b1111001: nib = 4'h1;
            7'b0100100: nib = 4'h2;
            7'b0110000: nib = 4'h3;
            7'b0011001: nib = 4'h4;
            7'b0010010: nib = 4'h5;
            7'b0000010: nib = 4'h6;
            7'b1111000: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0010000: nib = 4'h9;
            7'b0011000: nib = 4'h9;
            7'b0001000: nib = 4'hA;
            7'b0000011: nib = 4'hB;
            7'b1000110: nib = 4'hC;
            7'b0100001: nib = 4'hD;
            7'b0000110: nib = 4'hE;
            7'b0001110: nib = 4'hF;
            default:    bad = 1'b1;
        endcase
    end

    assign same = (sample == prev);

    always_comb begin
        cnt_nxt = cnt;
        if (!legal) begin
            cnt_nxt = 4'd0;
        end else if (!same) begin
            cnt_nxt = 4'd1;
        end else if (cnt != STABLE) begin
            cnt_nxt = cnt + 4'd1;
        end
    end

    // Fires only on the edge the counter climbs into saturation, so a
    // digit held indefinitely is captured once.
    assign capture    = legal && same && (cnt == STABLE_M1);
    assign frame_done = &mask;

    // Capture path: runs every cycle regardless of the output state.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev     <= BLANK;
            cnt      <= 4'd0;
            mask     <= 4'b0000;
            slot_val <= 16'h0000;
            slot_err <= 4'b0000;
`ifdef SEG7_SCAN_RX_DP_EN
            slot_dp  <= 4'b0000;
`endif
        end else begin
            prev <= sample;
            cnt  <= cnt_nxt;
            mask <= (frame_done ? 4'b0000 : mask) | (capture ? hot : 4'b0000);
            if (capture) begin
                slot_val[{sel, 2'b00} +: 4] <= nib;
                slot_err[sel]               <= bad;
`ifdef SEG7_SCAN_RX_DP_EN
                slot_dp[sel]                <= ~dp_i;
`endif
            end
        end
    end

    // Output FSM: a completed mask is published one edge later. In FULL the
    // frame is only replaced when the held one is taken in the same cycle;
    // otherwise it is dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= EMPTY;
            value_o     <= 16'h0000;
            valid_o     <= 1'b0;
            err_o       <= 1'b0;
            digit_err_o <= 4'b0000;
            overrun_o   <= 1'b0;
`ifdef SEG7_SCAN_RX_DP_EN
            dp_o        <= 4'b0000;
`endif
        end else begin
            case (state)
                EMPTY: begin
                    if (frame_done) begin
                        state       <= FULL;
                        valid_o     <= 1'b1;
                        value_o     <= slot_val;
                        digit_err_o <= slot_err;
                        err_o       <= |slot_err;
`ifdef SEG7_SCAN_RX_DP_EN
                        dp_o        <= slot_dp;
`endif
                    end
                end
                FULL: begin
                    if (frame_done) begin
                        if (ready_i) begin
                            valid_o     <= 1'b1;
                            value_o     <= slot_val;
                            digit_err_o <= slot_err;
                            err_o       <= |slot_err;
`ifdef SEG7_SCAN_RX_DP_EN
                            dp_o        <= slot_dp;
`endif
                        end else begin
                            overrun_o <= 1'b1;
                        end
                    end else if (ready_i) begin
                        state   <= EMPTY;
                        valid_o <= 1'b0;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_rx.sv
// tb_seg7_scan_rx: directed bench for seg7_scan_rx (default build).
// Drives scanned digit frames and checks the held frame and flags.

module tb_seg7_scan_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_i;
    logic [3:0]  an_i;
    logic        ready_i;
    logic [15:0] value_o;
    logic        valid_o;
    logic        err_o;
    logic [3:0]  digit_err_o;
    logic        overrun_o;

    int checks   = 0;
    int failures = 0;

    seg7_scan_rx #(.STABLE_CNT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_i       (seg_i),
        .an_i        (an_i),
        .ready_i     (ready_i),
        .value_o     (value_o),
        .valid_o     (valid_o),
        .err_o       (err_o),
        .digit_err_o (digit_err_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] h);
        case (h)
            4'h0: enc = 7'b1000000;
            4'h1: enc = 7'b1111001;
            4'h2: enc = 7'b0100100;
            4'h3: enc = 7'b0110000;
            4'h4: enc = 7'b0011001;
            4'h5: enc = 7'b0010010;
            4'h6: enc = 7'b0000010;
            4'h7: enc = 7'b1111000;
            4'h8: enc = 7'b0000000;
            4'h9: enc = 7'b0010000;
            4'hA: enc = 7'b0001000;
            4'hB: enc = 7'b0000011;
            4'hC: enc = 7'b1000110;
            4'hD: enc = 7'b0100001;
            4'hE: enc = 7'b0000110;
            default: enc = 7'b0001110;
        endcase
    endfunction

    task automatic hold(input int d, input logic [6:0] s, input int n);
        an_i    = 4'b1111;
        an_i[d] = 1'b0;
        seg_i   = s;
        step(n);
    endtask

    task automatic frame(input logic [15:0] v);
        for (int d = 3; d >= 0; d--) begin
            hold(d, enc(v[d*4 +: 4]), 4);
        end
    endtask

    task automatic ack();
        ready_i = 1'b1;
        step(1);
        ready_i = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        an_i    = 4'b1111;
        seg_i   = 7'h7F;
        ready_i = 1'b0;
        step(2);
        rst = 1'b0;
        chk("rst_value", 32'(value_o), 32'h0);
        chk("rst_valid", 32'(valid_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_derr", 32'(digit_err_o), 32'h0);
        chk("rst_ovr", 32'(overrun_o), 32'h0);

        // Basic frame and one-cycle publish latency
        frame(16'h1234);
        chk("lat_pre", 32'(valid_o), 32'h0);
        an_i = 4'b1111;
        step(1);
        chk("f1_valid", 32'(valid_o), 32'h1);
        chk("f1_value", 32'(value_o), 32'h1234);
        chk("f1_err", 32'(err_o), 32'h0);
        chk("f1_derr", 32'(digit_err_o), 32'h0);
        ack();
        chk("f1_ack", 32'(valid_o), 32'h0);

        // Unrecognised pattern on digit 0
        hold(3, enc(4'h5), 4);
        hold(2, enc(4'h6), 4);
        hold(1, enc(4'h7), 4);
        hold(0, 7'b1111111, 4);
        an_i = 4'b1111;
        step(1);
        chk("bad_valid", 32'(valid_o), 32'h1);
        chk("bad_value", 32'(value_o), 32'h5670);
        chk("bad_derr", 32'(digit_err_o), 32'h1);
        chk("bad_err", 32'(err_o), 32'h1);
        ack();

        // Too-short holds and a ghost anode state capture nothing
        for (int d = 3; d >= 0; d--) begin
            hold(d, enc(4'h8), 3);
        end
        an_i = 4'b1111;
        step(3);
        chk("short_valid", 32'(valid_o), 32'h0);
        an_i  = 4'b1100;
        seg_i = enc(4'h3);
        step(8);
        an_i = 4'b1111;
        step(1);
        hold(3, enc(4'h9), 4);
        hold(2, enc(4'h8), 4);
        hold(1, enc(4'h7), 4);
        an_i = 4'b1111;
        step(2);
        chk("ghost_valid", 32'(valid_o), 32'h0);
        hold(0, enc(4'hC), 4);
        an_i = 4'b1111;
        step(1);
        chk("g_valid", 32'(valid_o), 32'h1);
        chk("g_value", 32'(value_o), 32'h987C);
        chk("g_ovr", 32'(overrun_o), 32'h0);
        ack();

        // Overrun: second frame dropped while first is held
        frame(16'h1357);
        an_i = 4'b1111;
        step(1);
        chk("o1_value", 32'(value_o), 32'h1357);
        chk("o1_ovr", 32'(overrun_o), 32'h0);
        frame(16'hABCD);
        an_i = 4'b1111;
        step(1);
        chk("o2_valid", 32'(valid_o), 32'h1);
        chk("o2_value", 32'(value_o), 32'h1357);
        chk("o2_ovr", 32'(overrun_o), 32'h1);
        ack();
        chk("o2_ack", 32'(valid_o), 32'h0);
        chk("o2_sticky", 32'(overrun_o), 32'h1);

        // Handshake in the same cycle a new frame completes
        frame(16'h4321);
        an_i = 4'b1111;
        step(1);
        chk("h1_value", 32'(value_o), 32'h4321);
        frame(16'h0F0F);
        ready_i = 1'b1;
        an_i    = 4'b1111;
        step(1);
        ready_i = 1'b0;
        chk("h2_valid", 32'(valid_o), 32'h1);
        chk("h2_value", 32'(value_o), 32'h0F0F);
        step(1);
        chk("h2_hold", 32'(valid_o), 32'h1);
        ack();
        chk("h2_ack", 32'(valid_o), 32'h0);

        // Reset mid-frame discards the partial mask and the sticky flag
        hold(3, enc(4'h9), 4);
        hold(2, enc(4'h9), 4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("r_valid", 32'(valid_o), 32'h0);
        chk("r_ovr", 32'(overrun_o), 32'h0);
        chk("r_value", 32'(value_o), 32'h0);
        hold(1, enc(4'h7), 4);
        hold(0, enc(4'h8), 4);
        an_i = 4'b1111;
        step(2);
        chk("r_mask", 32'(valid_o), 32'h0);
        hold(3, enc(4'h5), 4);
        hold(2, enc(4'h6), 4);
        an_i = 4'b1111;
        step(1);
        chk("r2_valid", 32'(valid_o), 32'h1);
        chk("r2_value", 32'(value_o), 32'h5678);
        chk("r2_ovr", 32'(overrun_o), 32'h0);
        ack();

        // E and the alternate 9 pattern
        hold(3, enc(4'hE), 4);
        hold(2, 7'b0011000, 4);
        hold(1, enc(4'h0), 4);
        hold(0, enc(4'h6), 4);
        an_i = 4'b1111;
        step(1);
        chk("alt_value", 32'(value_o), 32'hE906);
        chk("alt_err", 32'(err_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_rx.md
# seg7_scan_rx

Receive-side companion to the hex-to-seven-segment encoder. It samples a time-multiplexed, active-low 4-digit seven-segment bus (segment lines plus digit anodes) and validates each digit over consecutive stable samples. It decodes each segment pattern back to a 4-bit hex nibble and presents the assembled 16-bit value through a valid/ready handshake. It is used by on-board self-check logic and loopback benches to read back what the display path drives.

## Interface
- STABLE_CNT, 4: consecutive identical samples required to accept a digit; legal range 2..15.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- seg_i  in  7  segment lines, active-low, bit6..bit0 = g,f,e,d,c,b,a; same clock domain, no synchronizer.
- an_i  in  4  digit anodes, active-low; an_i[3] = most significant digit.
- ready_i  in  1  consumer accepts the held frame when high with valid_o.
- value_o  out  16  decoded frame; digit n occupies nibble n.
- valid_o  out  1  frame held; level signal until accepted.
- err_o  out  1  held frame contains at least one unrecognised pattern.
- digit_err_o  out  4  per-digit unrecognised-pattern flags for the held frame.
- overrun_o  out  1  sticky flag; a completed frame was dropped.

## Operation
- A sample is legal only when an_i has exactly one bit low. If an_i = 4'b1111 (blank) or two or more bits are low (ghost), the stability counter clears to 0 and nothing is captured.
- If a legal sample {an_i, seg_i} equals the previous cycle's sample, the counter increments, saturating at STABLE_CNT. Otherwise it loads 1.
- On the edge where the counter reaches STABLE_CNT, the decoded nibble and its error bit are written to the shadow slot for the selected digit, and that digit's mask bit is set. Once saturated, the same digit is not re-captured until the sample changes.
- Decode table (seg_i → nibble):
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7.
  - 0000000→8, 0010000→9, 0011000→9, 0001000→A, 0000011→b, 1000110→C, 0100001→d, 0000110→E, 0001110→F.
  - Any other pattern decodes to nibble 0 with the slot error bit set.
- Re-capturing a digit already in the mask within the same frame overwrites its slot.
- The output FSM has two states, EMPTY and FULL:
  - EMPTY: when the mask becomes 4'b1111, on the next edge load value_o and digit_err_o from the shadow slots, set err_o = |slot errors, clear the mask, go to FULL.
  - FULL: on valid_o && ready_i, go to EMPTY.
  - If a frame completes in FULL without ready_i, the frame is discarded, the mask clears, and overrun_o sets.
  - If a frame completes in the same cycle as the handshake, the new frame loads and the FSM stays FULL with no gap in valid_o.
- Capture runs continuously in both states.

## Timing
- Reset values: value_o = 0, valid_o = 0, err_o = 0, digit_err_o = 0, overrun_o = 0, FSM in EMPTY, mask = 0, counter = 0, previous sample = blank.
- A digit stable from cycle k is captured at the edge ending cycle k+STABLE_CNT-1.
- valid_o rises one cycle after the edge that completes the mask.
- Minimum frame latency: 4×STABLE_CNT+1 cycles from the first stable sample of the first digit.
- Asserting rst mid-frame discards the partial mask and any held frame. overrun_o clears only on rst.

## Configuration
- SEG7_SCAN_RX_DP_EN defined:
  - Adds input dp_i (1 bit, active-low decimal point) and output dp_o (4 bits, active-high, per digit, held with value_o).
  - dp_i participates in the stability comparison.
  - dp_o resets to 0.
- SEG7_SCAN_RX_DP_EN undefined: neither port exists, and the decimal point is not sampled.

## Test plan
- Reset, then scan digits 3,2,1,0 with patterns for 1, 2, 3, 4, each held 4 cycles, ready_i = 0 → valid_o = 1, value_o = 16'h1234, err_o = 0, one cycle after the last capture.
- Hold digit 0 with pattern 1111111 for 4 cycles within an otherwise valid frame → digit_err_o = 4'b0001, err_o = 1, nibble 0 = 0.
- Hold each digit only 3 cycles (STABLE_CNT = 4) → valid_o stays 0. Drive an_i = 4'b1100 → no capture.
- With valid_o held and ready_i = 0, complete a second frame 16'hABCD → value_o keeps the first frame and overrun_o = 1. Pulse ready_i → valid_o = 0.
- Assert ready_i in the same cycle a frame 16'h0F0F completes → valid_o stays 1 and value_o = 16'h0F0F.
- Assert rst after 2 digits are captured, then scan a full frame 16'h5678 → value_o = 16'h5678, overrun_o = 0.
